// File: rtl/coin_change_dispenser.sv
// Coin/soda dispense sequencer.
// Queues vend transactions (change owed, in nickels) from the vending FSM and
// plays each one out on the physical mechanisms: one soda drop, then change
// paid greedily as dimes followed by at most one nickel. Every request is a
// req/ack handshake separated by a one-cycle all-low gap. A watchdog moves the
// block into a sticky FAULT state if a mechanism never acknowledges.
module coin_change_dispenser #(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 1000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       vend_i,
    input  logic [2:0] change_i,
    input  logic       soda_ack_i,
    input  logic       coin_ack_i,
    output logic       soda_req_o,
    output logic       dime_req_o,
    output logic       nickel_req_o,
    output logic       busy_o,
    output logic       full_o,
    output logic       drop_o,
    output logic       fault_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [TW-1:0] WD_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SODA,
        S_GAP,
        S_COIN,
        S_FAULT
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_rem;
    logic [2:0]    w_rem_nxt;
    logic [TW-1:0] r_wd;
    logic [TW-1:0] w_wd_nxt;

    logic [2:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_drop;

    logic          w_pop;
    logic          w_push;
    logic [2:0]    w_head;

    assign w_head = r_mem[r_rptr];

    // A slot freed by a pop on the same edge may be reused by the incoming vend.
    assign w_push = vend_i && ((r_count != DEPTH_C) || w_pop);

    assign busy_o  = (r_state != S_IDLE) || (r_count != '0);
    assign full_o  = (r_count == DEPTH_C);
    assign fault_o = (r_state == S_FAULT);
    assign drop_o  = r_drop;

    // FIFO payload storage; contents are only meaningful below r_count.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= change_i;
        end
    end

    // FIFO pointers, occupancy and the lost-vend pulse.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= vend_i && !w_push;
            if (w_push) begin
                r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sequencer state, remaining change and watchdog registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_wd    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_wd    <= w_wd_nxt;
        end
    end

    // Next-state logic and Moore request decode; acks only count in their own state.
    always_comb begin
        w_state_nxt  = r_state;
        w_rem_nxt    = r_rem;
        w_wd_nxt     = r_wd;
        w_pop        = 1'b0;
        soda_req_o   = 1'b0;
        dime_req_o   = 1'b0;
        nickel_req_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_rem_nxt   = w_head;
                    w_wd_nxt    = '0;
                    w_state_nxt = S_SODA;
                end
            end
            S_SODA: begin
                soda_req_o = 1'b1;
                if (soda_ack_i) begin
                    w_state_nxt = S_GAP;
                end else if (r_wd == WD_LAST) begin
                    w_state_nxt = S_FAULT;
                end else begin
                    w_wd_nxt = r_wd + TW'(1);
                end
            end
            S_GAP: begin
                if (r_rem == 3'd0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_wd_nxt    = '0;
                    w_state_nxt = S_COIN;
                end
            end
            S_COIN: begin
                dime_req_o   = (r_rem >= 3'd2);
                nickel_req_o = (r_rem == 3'd1);
                if (coin_ack_i) begin
                    w_rem_nxt   = r_rem - ((r_rem >= 3'd2) ? 3'd2 : 3'd1);
                    w_state_nxt = S_GAP;
                end else if (r_wd == WD_LAST) begin
                    w_state_nxt = S_FAULT;
                end else begin
                    w_wd_nxt = r_wd + TW'(1);
                end
            end
            S_FAULT: begin
                w_state_nxt = S_FAULT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Bench for coin_change_dispenser: a transaction-level reference model
// (queue of pending change values plus an expanded list of mechanism actions
// for the transaction in progress) is compared against the DUT every cycle,
// alongside a hand-written vector table and directed corner-case sequences.
module tb_coin_change_dispenser;

    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 8;
    localparam int A_SODA  = 0;
    localparam int A_DIME  = 1;
    localparam int A_NICK  = 2;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       vend_i;
    logic [2:0] change_i;
    logic       soda_ack_i;
    logic       coin_ack_i;
    logic       soda_req_o;
    logic       dime_req_o;
    logic       nickel_req_o;
    logic       busy_o;
    logic       full_o;
    logic       drop_o;
    logic       fault_o;
    logic [6:0] dut_out;

    always #5 clk = ~clk;

    coin_change_dispenser #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .vend_i      (vend_i),
        .change_i    (change_i),
        .soda_ack_i  (soda_ack_i),
        .coin_ack_i  (coin_ack_i),
        .soda_req_o  (soda_req_o),
        .dime_req_o  (dime_req_o),
        .nickel_req_o(nickel_req_o),
        .busy_o      (busy_o),
        .full_o      (full_o),
        .drop_o      (drop_o),
        .fault_o     (fault_o)
    );

    assign dut_out = {soda_req_o, dime_req_o, nickel_req_o, busy_o, full_o, drop_o, fault_o};

    int n_checks = 0;
    int n_err    = 0;

    // ---------------- reference model ----------------
    int m_q[$];      // pending change values, oldest first
    int m_act[$];    // remaining mechanism actions of the active transaction
    bit m_active;
    bit m_gap;
    bit m_fault;
    bit m_drop;
    int m_wd;

    function automatic void m_reset();
        m_q.delete();
        m_act.delete();
        m_active = 0;
        m_gap    = 0;
        m_fault  = 0;
        m_drop   = 0;
        m_wd     = 0;
    endfunction

    function automatic void m_step(input bit v, input int c, input bit sa, input bit ca);
        int sz;
        bit pop;
        bit ack;
        int c0;
        sz  = m_q.size();
        pop = !m_fault && !m_active && (sz > 0);
        if (m_fault) begin
        end else if (!m_active) begin
            if (sz > 0) begin
                c0 = m_q.pop_front();
                m_act.delete();
                m_act.push_back(A_SODA);
                for (int i = 0; i < c0 / 2; i++) m_act.push_back(A_DIME);
                if (c0 % 2 == 1) m_act.push_back(A_NICK);
                m_active = 1;
                m_gap    = 0;
                m_wd     = 0;
            end
        end else if (m_gap) begin
            if (m_act.size() == 0) m_active = 0;
            else begin
                m_gap = 0;
                m_wd  = 0;
            end
        end else begin
            ack = (m_act[0] == A_SODA) ? sa : ca;
            if (ack) begin
                void'(m_act.pop_front());
                m_gap = 1;
            end else if (m_wd + 1 >= TIMEOUT) m_fault = 1;
            else m_wd++;
        end
        m_drop = 0;
        if (v) begin
            if (sz < DEPTH || pop) m_q.push_back(c);
            else m_drop = 1;
        end
    endfunction

    function automatic logic [6:0] m_out();
        logic s, d, n;
        s = 0; d = 0; n = 0;
        if (!m_fault && m_active && !m_gap) begin
            s = (m_act[0] == A_SODA);
            d = (m_act[0] == A_DIME);
            n = (m_act[0] == A_NICK);
        end
        return {s, d, n, (m_active || m_q.size() != 0), (m_q.size() == DEPTH), m_drop, m_fault};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string nm, input logic [6:0] got, input logic [6:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b want %b (t=%0t)", nm, got, want, $time);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, got, want, $time);
        end
    endtask

    task automatic check_str(input string nm, input string got, input string want);
        n_checks++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got \"%s\" want \"%s\" (t=%0t)", nm, got, want, $time);
        end
    endtask

    // One clock: drive inputs at the negedge, step the model at the posedge,
    // compare at the following negedge.
    task automatic cycle(input bit v, input int c, input bit sa, input bit ca);
        vend_i     = v;
        change_i   = 3'(c);
        soda_ack_i = sa;
        coin_ack_i = ca;
        @(posedge clk);
        m_step(v, c, sa, ca);
        @(negedge clk);
        check("model", dut_out, m_out());
    endtask

    task automatic do_reset();
        reset_i = 1; vend_i = 0; change_i = 0; soda_ack_i = 0; coin_ack_i = 0;
        m_reset();
        @(posedge clk);
        @(negedge clk);
        check("reset", dut_out, 7'b0);
        reset_i = 0;
    endtask

    string g_seq;

    // Acknowledge each request after it has been visible for dly+1 cycles,
    // recording the order of served mechanisms, until the DUT goes idle.
    task automatic drain(input int dly);
        int  held;
        bit  sa, ca;
        bit  done;
        held = 0;
        done = 0;
        g_seq = "";
        for (int k = 0; k < 200 && !done; k++) begin
            sa = 0; ca = 0;
            if (soda_req_o || dime_req_o || nickel_req_o) begin
                if (held >= dly) begin
                    sa = soda_req_o;
                    ca = dime_req_o | nickel_req_o;
                    if (soda_req_o)   g_seq = {g_seq, "S"};
                    if (dime_req_o)   g_seq = {g_seq, "D"};
                    if (nickel_req_o) g_seq = {g_seq, "N"};
                    held = 0;
                end else held++;
            end
            cycle(0, 0, sa, ca);
            if (!busy_o) done = 1;
        end
        check_int("drain_idle", int'(busy_o), 0);
    endtask

    function automatic string expect_seq(input int c);
        string s;
        s = "S";
        for (int i = 0; i < c / 2; i++) s = {s, "D"};
        if (c % 2 == 1) s = {s, "N"};
        return s;
    endfunction

    typedef struct packed {
        logic       v;
        logic [2:0] c;
        logic       sa;
        logic       ca;
        logic [6:0] exp;   // {soda, dime, nickel, busy, full, drop, fault}
    } vec_t;

    vec_t tbl[8];

    initial begin
        int hi;
        // change 3: soda, dime, nickel; each ack on the request's second cycle
        tbl[0] = '{1'b1, 3'd3, 1'b0, 1'b0, 7'b0001000};
        tbl[1] = '{1'b0, 3'd0, 1'b0, 1'b0, 7'b1001000};
        tbl[2] = '{1'b0, 3'd0, 1'b1, 1'b0, 7'b0001000};
        tbl[3] = '{1'b0, 3'd0, 1'b0, 1'b0, 7'b0101000};
        tbl[4] = '{1'b0, 3'd0, 1'b0, 1'b1, 7'b0001000};
        tbl[5] = '{1'b0, 3'd0, 1'b0, 1'b0, 7'b0011000};
        tbl[6] = '{1'b0, 3'd0, 1'b0, 1'b1, 7'b0001000};
        tbl[7] = '{1'b0, 3'd0, 1'b0, 1'b0, 7'b0000000};

        reset_i = 1; vend_i = 0; change_i = 0; soda_ack_i = 0; coin_ack_i = 0;
        m_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_state", dut_out, 7'b0);
        reset_i = 0;

        // Test 1: change 0, slow soda ack
        cycle(1, 0, 0, 0);
        check_int("t1_busy_at_vend", int'(busy_o), 1);
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0);
            hi += int'(soda_req_o);
        end
        cycle(0, 0, 1, 0);
        hi += int'(soda_req_o);
        check_int("t1_soda_cycles", hi, 4);
        cycle(0, 0, 0, 0);
        check("t1_idle", dut_out, 7'b0);

        // Test 2: vector table for change 3, then model-checked 4 and 7
        foreach (tbl[i]) begin
            cycle(tbl[i].v, int'(tbl[i].c), tbl[i].sa, tbl[i].ca);
            check($sformatf("table_row%0d", i), dut_out, tbl[i].exp);
        end
        cycle(1, 4, 0, 0);
        drain(1);
        check_str("t2_change4", g_seq, expect_seq(4));
        cycle(1, 7, 0, 0);
        drain(1);
        check_str("t2_change7", g_seq, expect_seq(7));

        // Test 3: four back-to-back vends with DEPTH 2
        cycle(1, 1, 0, 0);
        cycle(1, 2, 0, 0);
        cycle(1, 3, 0, 0);
        check_int("t3_full", int'(full_o), 1);
        check_int("t3_no_drop_yet", int'(drop_o), 0);
        cycle(1, 4, 0, 0);
        check_int("t3_drop", int'(drop_o), 1);
        cycle(0, 0, 0, 0);
        check_int("t3_drop_one_cycle", int'(drop_o), 0);
        drain(0);
        check_str("t3_order", g_seq, "SNSDSDN");

        // Test 4: watchdog fault on a missing soda ack
        do_reset();
        cycle(1, 0, 0, 0);
        hi = 0;
        for (int k = 0; k < 20 && !fault_o; k++) begin
            cycle(0, 0, 0, 0);
            hi += int'(soda_req_o);
        end
        check_int("t4_req_cycles", hi, TIMEOUT);
        check_int("t4_fault", int'(fault_o), 1);
        check_int("t4_soda_low", int'(soda_req_o), 0);
        cycle(1, 1, 0, 0);
        cycle(1, 2, 0, 0);
        check_int("t4_full", int'(full_o), 1);
        cycle(1, 3, 0, 0);
        check_int("t4_drop", int'(drop_o), 1);
        cycle(0, 0, 1, 1);
        check_int("t4_fault_sticky", int'(fault_o), 1);
        do_reset();

        // Test 5: stray coin acks, ack coinciding with watchdog expiry
        cycle(0, 0, 0, 1);
        cycle(1, 2, 0, 1);
        cycle(0, 0, 0, 1);
        for (int k = 0; k < TIMEOUT - 1; k++) cycle(0, 0, 0, 1);
        check_int("t5_still_soda", int'(soda_req_o), 1);
        cycle(0, 0, 1, 0);
        check_int("t5_no_fault", int'(fault_o), 0);
        drain(0);
        check_str("t5_seq", g_seq, "D");

        // Test 6: asynchronous reset in the middle of a dime request
        cycle(1, 4, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 2, 1, 0);
        cycle(0, 0, 0, 0);
        check_int("t6_dime_high", int'(dime_req_o), 1);
        reset_i = 1;
        m_reset();
        #1;
        check("t6_async_drop", dut_out, 7'b0);
        @(negedge clk);
        reset_i = 0;
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("t6_after_reset", dut_out, 7'b0);

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            cycle(($urandom % 4) == 0, int'($urandom % 8),
                  ($urandom % 2) == 0, ($urandom % 2) == 0);
        end
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/coin_change_dispenser.md
# coin_change_dispenser

Downstream stage of the soda vending FSM. It consumes the FSM's one-cycle vend strobe (`soda_o`) and change amount (`change_o`, in nickel units) and queues each transaction in a small FIFO. It then drives the physical dispense mechanisms through req/ack handshakes: first the soda drop, then change paid greedily as dimes followed by at most one nickel. A watchdog latches a sticky fault if any mechanism fails to acknowledge.

## Interface
- `DEPTH`, default 2: FIFO entries (pending transactions), ≥1.
- `TIMEOUT`, default 1000: max cycles a request may stay high without ack, ≥2.

- `clk_i` in 1: clock, rising edge.
- `reset_i` in 1: asynchronous, active-high reset.
- `vend_i` in 1: one-cycle vend strobe, driven by the vending FSM `soda_o`.
- `change_i` in 3: change owed in nickels (0–7), sampled only with `vend_i`. Driven by FSM `change_o`.
- `soda_ack_i` in 1: soda mechanism done.
- `coin_ack_i` in 1: coin mechanism done (dime or nickel).
- `soda_req_o` out 1: request one soda drop.
- `dime_req_o` out 1: request one dime.
- `nickel_req_o` out 1: request one nickel.
- `busy_o` out 1: state≠IDLE or FIFO non-empty.
- `full_o` out 1: FIFO count == `DEPTH`.
- `drop_o` out 1: one-cycle pulse, vend lost (FIFO full).
- `fault_o` out 1: sticky watchdog fault.

## Operation
- FIFO stores `change_i`.
  - Push on `vend_i` if count<`DEPTH`, or if a pop occurs the same edge.
  - Otherwise the vend is discarded and `drop_o` pulses for the following cycle.
  - Order is preserved.
- Remaining-change register `rem`, 3 bits.
- FSM states: IDLE, SODA, GAP, COIN, FAULT.
- IDLE: if FIFO non-empty, pop the head into `rem` and go to SODA.
- SODA: `soda_req_o`=1. On `soda_ack_i` go to GAP.
- GAP: all requests low for exactly one cycle. If `rem`==0 go to IDLE, else go to COIN.
- COIN: `dime_req_o`=1 if `rem`≥2, else `nickel_req_o`=1 (`rem`==1). Request outputs are Moore outputs, decoded from state and `rem`.
  - On `coin_ack_i`: `rem` -= 2 (dime) or 1 (nickel), then go to GAP.
- Acks outside their matching request state are ignored. `coin_ack_i` in SODA and `soda_ack_i` in COIN have no effect.
- Watchdog counter:
  - Clears on entry to SODA or COIN and counts every cycle spent there.
  - If it reaches `TIMEOUT` with no ack sampled, go to FAULT and set `fault_o`.
  - Ack and timeout on the same edge: ack wins.
- FAULT:
  - All requests low; no pops.
  - FIFO keeps its contents and still accepts pushes until full; further vends are dropped.
  - Only reset exits FAULT.
- Change sequence: 0 → none; 1 → N; 2 → D; 3 → D,N; 4 → D,D; 7 → D,D,D,N.

## Timing
- Reset (async assert) sets:
  - State IDLE; FIFO empty; `rem`=0; watchdog=0.
  - All outputs 0, including `fault_o`.
- Reset mid-transaction: any request drops immediately and all queued vends are discarded.
- Latency, empty FIFO in IDLE: with `vend_i` sampled at edge E, `soda_req_o` is high from E+1 (one cycle). `busy_o` is high from E.
- Handshake:
  - A request stays high until its ack is sampled high at edge A.
  - The request goes low after A; GAP occupies cycle A..A+1.
  - The next request is high from A+1, or IDLE is entered at A+1.
- Minimum transaction time for change n: (2 + 2·coins) cycles with zero-wait acks.
- Simultaneous `vend_i` and pop with count==`DEPTH`: push accepted, no `drop_o`.
- `full_o` and `busy_o` are registered-state decodes, valid the cycle after the push or pop.

## Test plan
1. `vend_i` with `change_i`=0, `soda_ack_i` 3 cycles after request → `soda_req_o` high 1 cycle after the vend and for exactly 4 cycles, no coin requests; IDLE and `busy_o`=0 two cycles after ack.
2. `change_i`=3 (35¢ paid), all acks after 1 cycle → sequence soda, dime, nickel, each separated by a one-cycle low gap. Repeat with `change_i`=4 → 2 dimes, and `change_i`=7 → 3 dimes + 1 nickel.
3. `DEPTH`=2, four `vend_i` strobes on consecutive cycles (change 1,2,3,4) while the first soda is unacked:
   - Strobes 1–3 are accepted (pop frees a slot); `full_o`=1.
   - The 4th strobe produces `drop_o`.
   - After acks, payouts are N; D; D,N, in order.
4. `TIMEOUT`=8, no `soda_ack_i` → `fault_o` rises after the 8th request cycle; `soda_req_o` low; later vends fill the FIFO then pulse `drop_o`; `reset_i` clears everything.
5. `coin_ack_i` pulses during SODA and while idle are ignored. An ack on the same edge the watchdog expires proceeds normally with no fault.
6. Assert `reset_i` mid-COIN with 2 entries queued → `dime_req_o` drops asynchronously. After release: `busy_o`=0, no requests.
